// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard controller
package pipe_pkg;
    localparam int REG_W_DEF = 5;
    localparam int CNT_W_DEF = 16;
    localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FREEZE = 2'd2} state_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_W_DEF-1:0] dst;
    } sb_entry_t;

    function automatic logic sb_hit(sb_entry_t e, logic [REG_W_DEF-1:0] src, logic en);
        return en && e.valid && src != ZERO_REG && e.dst == src;
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] out
);
    always_ff @(posedge clk)
        out <= !rst_n ? '0 : (inc && !(&out)) ? out + 1'b1 : out;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW stall, branch flush and freeze sequencing for a 5-stage pipeline
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             idUsesRs,
    input  logic             idUsesRt,
    input  logic [REG_W-1:0] idDst,
    input  logic             idRegWrite,
    input  logic             branchTaken,
    input  logic             freezeReq,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexBubble,
    output logic             exmemFlush,
    output logic             pipeEn,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushEvents
);
    sb_entry_t sb_ex, sb_mem;
    state_t    st, st_n;
    logic      hazard, flush, stall;

    assign hazard = sb_hit(sb_ex, idRs, idUsesRs) || sb_hit(sb_mem, idRs, idUsesRs) ||
                    sb_hit(sb_ex, idRt, idUsesRt) || sb_hit(sb_mem, idRt, idUsesRt);
    assign flush  = !freezeReq && branchTaken;
    assign stall  = !freezeReq && !branchTaken && hazard;

    assign pcWrite    = !freezeReq && !stall;
    assign ifidWrite  = !freezeReq && !stall;
    assign ifidFlush  = flush;
    assign idexBubble = flush || stall;
    assign exmemFlush = flush;
    assign pipeEn     = !freezeReq;
    assign state      = st;

    always_comb st_n = freezeReq ? FREEZE : stall ? STALL : RUN;

    // a stalled or flushed ID slot enters EX as a bubble, so it never becomes a writer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            st     <= RUN;
        end else begin
            st <= st_n;
            if (!freezeReq) begin
                sb_mem <= flush ? '0 : sb_ex;
                sb_ex  <= (flush || stall) ? '0 :
                          sb_entry_t'{valid: idRegWrite && idDst != ZERO_REG, dst: idDst};
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .rst_n(rst_n), .inc(stall), .out(stallCycles));
    sat_counter #(.W(CNT_W)) u_flush (.clk(clk), .rst_n(rst_n), .inc(flush), .out(flushEvents));
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). The datapath has no forwarding.
- Keeps a 2-entry scoreboard of in-flight register writers (EX, MEM). Detects RAW hazards on the instruction in ID.
- Stalls the front end and injects bubbles while a hazard is open. Flushes younger stages when a branch resolves taken in MEM.
- Honors a global freeze request and keeps saturating performance counters.

Parameters:
- REG_W, 5, register index width
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous reset, active-low
- idRs  in  REG_W  rs field of the ID instruction (insActual[25:21])
- idRt  in  REG_W  rt field of the ID instruction (insActual[20:16])
- idUsesRs  in  1  ID instruction reads rs
- idUsesRt  in  1  ID instruction reads rt
- idDst  in  REG_W  ID destination after regDst selection
- idRegWrite  in  1  ID instruction writes the register file
- branchTaken  in  1  branch AND zero from MEM stage (CAND output)
- freezeReq  in  1  external hold of the whole pipeline
- pcWrite  out  1  PC load enable
- ifidWrite  out  1  IF/ID load enable
- ifidFlush  out  1  IF/ID loads NOP
- idexBubble  out  1  ID/EX loads all-zero controls
- exmemFlush  out  1  EX/MEM loads all-zero controls
- pipeEn  out  1  EX/MEM and MEM/WB load enable
- state  out  2  0 RUN, 1 STALL, 2 FREEZE
- stallCycles  out  CNT_W  count of hazard-stall cycles
- flushEvents  out  CNT_W  count of taken-branch flushes

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Scoreboard entries sbEx and sbMem become invalid.
  - Counters go to 0 and state goes to RUN.
  - Reset overrides every other input in that cycle. Reset asserted mid-stall or mid-freeze returns to RUN the next cycle.
- Scoreboard entry format: {valid, dst}.
  - An entry is valid only if its regWrite=1 and dst≠0.
  - WB is not tracked: the register file write is visible to ID in the same cycle.
- Hazard (combinational): hazard = valid entry in sbEx or sbMem whose dst equals idRs (with idUsesRs=1) or idRt (with idUsesRt=1). A source index of 0 never hazards.
- Priority per cycle: freezeReq > branchTaken > hazard > normal.
- FREEZE (freezeReq=1):
  - All enables 0 and all flush/bubble outputs 0. Scoreboard and counters hold.
  - state=FREEZE.
  - branchTaken is ignored; the source holds it stable, so it is acted on in the first unfrozen cycle.
- FLUSH (branchTaken=1, no freeze):
  - ifidFlush=1, idexBubble=1, exmemFlush=1, pcWrite=1, ifidWrite=1, pipeEn=1.
  - Both sbEx and sbMem are cleared next cycle.
  - flushEvents increments; state=RUN.
  - The hazard is masked, so stallCycles does not increment.
- STALL (hazard, no freeze, no branch):
  - pcWrite=0, ifidWrite=0, idexBubble=1, pipeEn=1.
  - sbMem takes sbEx; sbEx becomes invalid.
  - stallCycles increments; state=STALL.
- RUN (otherwise):
  - pcWrite=ifidWrite=pipeEn=1; flush and bubble outputs are 0.
  - sbMem takes sbEx; sbEx takes {idRegWrite && idDst≠0, idDst}.
- Latency:
  - A dependent instruction directly behind a writer stalls exactly 2 cycles.
  - With one unrelated instruction between them it stalls 1 cycle.
  - With two or more between them there is no stall.
- Counters saturate at all-ones and never wrap.
- The state register is registered. It reflects the current-cycle decision one cycle late; it is for debug only.
- All control outputs are combinational from the inputs and the scoreboard, so the same-cycle response is zero latency.

Decomposition:
- Shared package pipe_pkg:
  - state encoding (RUN/STALL/FREEZE)
  - scoreboard entry struct {valid, dst}
  - REG_W and CNT_W defaults
  - ZERO_REG constant
- One natural sub-module: sat_counter (width parameter, inc, rst_n, out). It is instantiated twice.

Test Plan:
- Hazard 1-behind: issue `add $3,$1,$2` (idDst=3, regWrite=1), then ID with idRs=3, idUsesRs=1.
  - Required: pcWrite=0, idexBubble=1 for exactly 2 cycles, then RUN.
  - Required: stallCycles=2.
- Gap 1 and gap 2: writer $5, one independent instruction, then a reader of $5.
  - Required: 1-cycle stall.
  - With two independent instructions in between: 0 stall cycles.
- Zero register: writer idDst=0 with regWrite=1, next reader idRs=0.
  - Required: no stall, and sbEx stays invalid.
- Branch during hazard: stall active and branchTaken=1 in the same cycle.
  - Required: ifidFlush=idexBubble=exmemFlush=1, pcWrite=1.
  - Required: scoreboard empty next cycle, flushEvents=1, stallCycles unchanged.
- Freeze: freezeReq=1 for 3 cycles during STALL.
  - Required: all enables 0 and state=FREEZE; stallCycles and scoreboard held.
  - On release the stall resumes and completes its remaining cycles.
- Reset and saturation:
  - rst_n=0 mid-stall: next cycle state=RUN, counters 0, no hazard.
  - Force 65540 stall cycles: stallCycles reads 65535.
